// File: rtl/watch_pkg.sv
// Shared types, field moduli and BCD helper
// for the watch time-keeping datapath.
package watch_pkg;

    typedef logic [3:0] bcd_t;

    localparam int MOD_SEC  = 60;
    localparam int MOD_MIN  = 60;
    localparam int MOD_HOUR = 24;

    // Binary 0..99 to {tens, units} BCD.
    function automatic logic [7:0] bin2bcd7(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = v / 7'd10;
        ones = v % 7'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/hour12_map.sv
// 24-hour BCD value to 12-hour display digits
// plus PM flag.
module hour12_map
    import watch_pkg::*;
(
    input  logic [3:0] t_i,
    input  logic [3:0] u_i,
    output logic [3:0] d1_o,
    output logic [3:0] d0_o,
    output logic       pm_o
);

    logic [6:0] val;
    logic [6:0] hr;
    logic [7:0] bcd;

    // Fold 0..23 onto 12,1..11 and flag the afternoon half.
    always_comb begin
        val  = {3'b000, t_i} * 7'd10 + {3'b000, u_i};
        hr   = val;
        pm_o = 1'b0;
        if (val >= 7'd12) begin
            pm_o = 1'b1;
            hr   = val - 7'd12;
        end
        if (hr == 7'd0) begin
            hr = 7'd12;
        end
        bcd  = bin2bcd7(hr);
        d1_o = bcd[7:4];
        d0_o = bcd[3:0];
    end

endmodule

// File: rtl/count_bcd_mod.sv
// Modulo-N two-digit BCD counter with carry,
// manual set and optional 12-hour display.
module count_bcd_mod
    import watch_pkg::*;
#(
    parameter int MODULUS = 24,
    parameter int INIT    = 0,
    parameter bit EN_12H  = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [6:0] load_val_i,
    input  logic       mode12_i,
    output logic [3:0] digit0_o,
    output logic [3:0] digit1_o,
    output logic       pm_o,
    output logic       carry_o,
    output logic       load_err_o
);

    localparam logic [7:0] MAX_BCD  = bin2bcd7(7'(MODULUS - 1));
    localparam logic [7:0] INIT_BCD = bin2bcd7(7'(INIT));
    localparam logic [6:0] MOD_BIN  = 7'(MODULUS);

    bcd_t t_q, t_d;
    bcd_t u_q, u_d;
    logic carry_q, carry_d;
    logic err_q, err_d;
    logic [7:0] load_bcd;

    // Next count: load beats step; tick and inc share one step.
    always_comb begin
        t_d      = t_q;
        u_d      = u_q;
        carry_d  = 1'b0;
        err_d    = 1'b0;
        load_bcd = bin2bcd7(load_val_i);
        if (load_i) begin
            if (load_val_i < MOD_BIN) begin
                t_d = load_bcd[7:4];
                u_d = load_bcd[3:0];
            end else begin
                err_d = 1'b1;
            end
        end else if (tick_i || inc_i) begin
            if ({t_q, u_q} == MAX_BCD) begin
                t_d     = 4'd0;
                u_d     = 4'd0;
                carry_d = tick_i;
            end else if (u_q == 4'd9) begin
                u_d = 4'd0;
                t_d = t_q + 4'd1;
            end else begin
                u_d = u_q + 4'd1;
            end
        end
    end

    // Count digits and pulse outputs, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            t_q     <= INIT_BCD[7:4];
            u_q     <= INIT_BCD[3:0];
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            t_q     <= t_d;
            u_q     <= u_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign carry_o    = carry_q;
    assign load_err_o = err_q;

    generate
        if (EN_12H) begin : g_12h
            if (MODULUS != 24) begin : g_bad
                $error("EN_12H requires MODULUS == 24");
            end

            logic [3:0] m1;
            logic [3:0] m0;
            logic       mpm;

            hour12_map u_map (
                .t_i  (t_q),
                .u_i  (u_q),
                .d1_o (m1),
                .d0_o (m0),
                .pm_o (mpm)
            );

            // Display mux; stored count is untouched by mode.
            always_comb begin
                digit1_o = t_q;
                digit0_o = u_q;
                pm_o     = 1'b0;
                if (mode12_i) begin
                    digit1_o = m1;
                    digit0_o = m0;
                    pm_o     = mpm;
                end
            end
        end else begin : g_24h
            logic unused_mode;
            assign unused_mode = mode12_i;
            assign digit1_o    = t_q;
            assign digit0_o    = u_q;
            assign pm_o        = 1'b0;
        end
    endgenerate

endmodule

// File: doc/count_bcd_mod.md
Name: count_bcd_mod

Overview:
- Generalised modulo-N time-digit counter for the watch datapath: seconds, minutes and hours all use this one block.
- Holds the count directly as two BCD digits, so no binary-to-digit LUT is needed, and advances on a single-cycle enable from the prescaler.
- Emits a wrap carry for chaining to the next field, supports manual set (increment and parallel load), and offers an optional 12-hour display mode with a PM flag.
- Sits between the 1 Hz tick prescaler and the 7-segment decoders.

Parameters:
- MODULUS, 24: count range 0..MODULUS-1; legal values 2..99 (60 for sec/min, 24 for hours).
- INIT, 0: value taken on reset; must be < MODULUS.
- EN_12H, 0: 1 enables the 12-hour display path. Legal only with MODULUS=24; elaboration error otherwise.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  synchronous reset, active-high.
- tick_i  in  1  count-enable pulse, one cycle wide, from the prescaler or the previous stage's carry_o.
- inc_i  in  1  manual increment pulse from the debounced set button.
- load_i  in  1  parallel load strobe.
- load_val_i  in  7  binary value to load.
- mode12_i  in  1  1 = 12-hour display (ignored when EN_12H=0).
- digit0_o  out  4  units digit, BCD.
- digit1_o  out  4  tens digit, BCD.
- pm_o  out  1  PM indicator (count >= 12, 12-hour mode only, else 0).
- carry_o  out  1  wrap pulse for chaining.
- load_err_o  out  1  rejected-load pulse.

Behaviour:
- All state changes happen on rising clk_i. rst_i takes priority over every other input.
- Internal state is two registered BCD digits, u (units) and t (tens), plus the registered pulses carry_o and load_err_o.
- Reset: {t,u} = INIT in BCD; carry_o=0; load_err_o=0.
- Priority per cycle: rst_i > load_i > (tick_i | inc_i) > hold.
- Load:
  - If load_val_i < MODULUS, {t,u} <= BCD(load_val_i) on the next edge.
  - Otherwise the count holds and load_err_o pulses for 1 cycle.
  - A load suppresses a same-cycle tick/inc; that tick is lost and no carry is produced.
- Increment (tick_i or inc_i, or both):
  - Exactly one step per cycle; tick and inc together advance by 1, not 2.
  - BCD step: if u==9, then u<=0 and t<=t+1; else u<=u+1.
  - If the count equals MODULUS-1, the next value is 0 (both digits).
  - Latency: the new value is visible 1 cycle after the enable.
- Carry:
  - carry_o=1 in the cycle the count shows 0 after a wrap, but only when tick_i was asserted in the wrap cycle.
  - A wrap caused by inc_i alone produces no carry, so setting minutes never disturbs hours.
  - carry_o is a 1-cycle pulse. Back-to-back ticks at MODULUS=2 give a carry every second cycle.
- Display:
  - digit0_o/digit1_o are combinational from {t,u} and mode12_i, adding no latency.
  - 24-hour mode, or EN_12H=0: outputs equal {t,u}; pm_o=0.
  - 12-hour mode mapping: 0→12 AM; 1..11→same, AM; 12→12 PM; 13..23→(count-12) PM. pm_o=1 for counts 12..23.
  - Switching mode12_i changes only the display, never the stored count.
- Out-of-range states never occur; there is no recovery logic beyond reset.

Decomposition:
- Shared package watch_pkg:
  - bcd_t (4-bit) typedef.
  - Constants for MOD_SEC=60, MOD_MIN=60, MOD_HOUR=24.
  - Function bin2bcd7 (7-bit binary to two BCD digits), reused by the load path and the alarm compare block.
- One sub-module, hour12_map: combinational BCD 24h→12h remap producing digits and pm. Instantiated under generate only when EN_12H=1.

Test Plan:
- Reset with INIT=23, MODULUS=24 → digit1_o=2, digit0_o=3, carry_o=0. Apply one tick_i → 0,0 next cycle with carry_o=1 for exactly 1 cycle.
- MODULUS=60 from 0 → 60 ticks. Digits pass 0,9 → 1,0 (BCD step, never 0xA) and 5,9 → 0,0. Exactly one carry_o pulse.
- At count 59 (MODULUS=60), assert inc_i only → count 0,0 with carry_o=0. Assert tick_i and inc_i together at 58 → 59, advancing by one only.
- load_val_i=17 → 1,7 next cycle. load_val_i=24 with MODULUS=24 → count unchanged, load_err_o=1 for 1 cycle. load_i and tick_i together at 05 with load_val_i=10 → 1,0, no carry.
- EN_12H=1, mode12_i=1: count 0 → 1,2 pm_o=0; 12 → 1,2 pm_o=1; 13 → 0,1 pm_o=1; 23 → 1,1 pm_o=1. Toggling mode12_i at 15 → 0,3 vs 1,5, internal count unchanged.
- Assert rst_i mid-count at 42 (MODULUS=60, INIT=0) together with tick_i → 0,0 next cycle, carry_o=0.
